// File: rtl/flappy_game_ctrl_pkg.sv
// Shared definitions for the flappy game-flow controller: state encoding,
// geometry constants shared with the bird block, and the BCD score helper.
package flappy_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [9:0] BIRD_X       = 10'd120;
    localparam logic [9:0] BIRD_SIZE    = 10'd48;
    localparam logic [9:0] PIPE_W       = 10'd64;
    localparam logic [8:0] GAP_H        = 9'd144;
    localparam logic [8:0] GROUND_Y     = 9'd416;
    localparam logic [8:0] SCREEN_H     = 9'd480;
    localparam logic [5:0] DEATH_FRAMES = 6'd30;
    localparam logic [7:0] BCD_MAX      = 8'h99;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/flappy_collide.sv
// Combinational bird-vs-pipe/ground/ceiling hit test and pipe-passed test.
// All arithmetic is done 11 bits wide so no sum can wrap.
module flappy_collide
    import flappy_game_ctrl_pkg::*;
(
    input  logic [8:0] bird_y,
    input  logic [9:0] pipe_x,
    input  logic [8:0] gap_y,
    input  logic [9:0] px_prev,
    output logic       hit,
    output logic       passed
);

    localparam logic [10:0] BIRD_L = {1'b0, BIRD_X};
    localparam logic [10:0] BIRD_R = {1'b0, BIRD_X + BIRD_SIZE};
    localparam logic [10:0] SIZE_W = {1'b0, BIRD_SIZE};
    localparam logic [10:0] PIPE_WW = {1'b0, PIPE_W};
    localparam logic [10:0] GAP_HW = {2'b00, GAP_H};
    localparam logic [10:0] GROUND_W = {2'b00, GROUND_Y};
    localparam logic [10:0] SCREEN_W = {2'b00, SCREEN_H};

    logic [10:0] by, gy, px, pp;
    logic [10:0] bird_bot, pipe_r, prev_r, gap_bot;
    logic        hx, hv;

    // Overlap tests on zero-extended operands.
    always_comb begin
        by       = {2'b00, bird_y};
        gy       = {2'b00, gap_y};
        px       = {1'b0, pipe_x};
        pp       = {1'b0, px_prev};
        bird_bot = by + SIZE_W;
        pipe_r   = px + PIPE_WW;
        prev_r   = pp + PIPE_WW;
        gap_bot  = gy + GAP_HW;
        hx       = (px < BIRD_R) && (pipe_r > BIRD_L);
        hv       = (by < gy) || (bird_bot > gap_bot);
        hit      = (hx && hv) || (bird_bot >= GROUND_W) || (by >= SCREEN_W);
        // pipe_x < px_prev filters out the upward jump on respawn
        passed   = (prev_r > BIRD_L) && (pipe_r <= BIRD_L) && (px < pp);
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Frame-paced game-flow controller (IDLE/PLAY/DYING/OVER) with BCD score.
// Optional feature: define HIGH_SCORE_EN to keep a best-score register.
// Handshake note: START is a level; only its registered rising edge
// (start_pe_q, one clk wide) advances the FSM, there is no ready side.
module flappy_game_ctrl
    import flappy_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       RESET_n,
    input  logic       fresh,
    input  logic       START,
    input  logic [8:0] bird_y,
    input  logic [9:0] pipe_x,
    input  logic [8:0] gap_y,
    output logic       game_status,
    output logic       Lose,
    output logic [7:0] score,
    output logic [7:0] best,
    output logic [1:0] dbg_state
);

    state_e     state_q, state_d;
    logic       fresh_q, fresh_d;
    logic       eval_q, eval_d;
    logic       start_q, start_d;
    logic       start_pe_q, start_pe_d;
    logic [5:0] dcnt_q, dcnt_d;
    logic [7:0] score_q, score_d;
    logic [9:0] px_prev_q, px_prev_d;
    logic       gs_q, gs_d;
    logic       lose_q, lose_d;
    logic [7:0] best_q, best_d;
    logic       frame_tick;
    logic       hit, passed;

    assign frame_tick = fresh_q & ~fresh;

    flappy_collide u_collide (
        .bird_y (bird_y),
        .pipe_x (pipe_x),
        .gap_y  (gap_y),
        .px_prev(px_prev_q),
        .hit    (hit),
        .passed (passed)
    );

    // Next-state logic: edge detectors, FSM, score and death counter.
    always_comb begin
        fresh_d    = fresh;
        eval_d     = frame_tick;
        start_d    = START;
        start_pe_d = START & ~start_q;
        px_prev_d  = eval_q ? pipe_x : px_prev_q;
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        score_d    = score_q;
        best_d     = best_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pe_q) begin
                    state_d = ST_PLAY;
                    score_d = 8'h00;
                end
            end
            ST_PLAY: begin
                if (eval_q) begin
                    if (hit) begin
                        state_d = ST_DYING;
                        dcnt_d  = 6'd0;
`ifdef HIGH_SCORE_EN
                        best_d  = (score_q > best_q) ? score_q : best_q;
`endif
                    end else if (passed) begin
                        score_d = bcd_inc(score_q);
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (dcnt_q == DEATH_FRAMES - 6'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        dcnt_d = dcnt_q + 6'd1;
                    end
                end
            end
            ST_OVER: begin
                if (start_pe_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gs_d   = (state_d == ST_PLAY);
        lose_d = (state_d == ST_DYING) || (state_d == ST_OVER);
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= ST_IDLE;
            fresh_q    <= 1'b0;
            eval_q     <= 1'b0;
            start_q    <= 1'b0;
            start_pe_q <= 1'b0;
            dcnt_q     <= 6'd0;
            score_q    <= 8'h00;
            px_prev_q  <= 10'd0;
            gs_q       <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fresh_q    <= fresh_d;
            eval_q     <= eval_d;
            start_q    <= start_d;
            start_pe_q <= start_pe_d;
            dcnt_q     <= dcnt_d;
            score_q    <= score_d;
            px_prev_q  <= px_prev_d;
            gs_q       <= gs_d;
            lose_q     <= lose_d;
        end
    end

`ifdef HIGH_SCORE_EN
    // Best score survives games and clears only on reset.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            best_q <= 8'h00;
        end else begin
            best_q <= best_d;
        end
    end
`else
    assign best_q = 8'h00;
`endif

    assign game_status = gs_q;
    assign Lose        = lose_q;
    assign score       = score_q;
    assign best        = best_q;
    assign dbg_state   = state_q;

endmodule
